// File: rtl/dco_tune_ctrl.sv
// Successive-approximation tuner for a ring-oscillator DCO: trims freq_sel_o MSB first
// until the external counter's measurement best matches the latched target count.
module dco_tune_ctrl #(
  parameter int CTRL_WIDTH     = 5,
  parameter int CNT_WIDTH      = 16,
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [CNT_WIDTH-1:0]  target_cnt_i,
  input  logic [CNT_WIDTH-1:0]  meas_cnt_i,
  input  logic                  meas_valid_i,
  output logic                  meas_req_o,
  output logic                  osc_enable_o,
  output logic [CTRL_WIDTH-1:0] freq_sel_o,
  output logic                  busy_o,
  output logic                  locked_o,
  output logic                  fault_o
);

  localparam int IDX_W    = (CTRL_WIDTH > 1) ? $clog2(CTRL_WIDTH) : 1;
  localparam int MAX_WAIT = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W    = $clog2(MAX_WAIT + 1);

  localparam logic [TMR_W-1:0]      SETTLE_LAST  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]      TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_MSB      = IDX_W'(CTRL_WIDTH - 1);
  localparam logic [CTRL_WIDTH-1:0] SEL_MSB      = CTRL_WIDTH'(1) << (CTRL_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_LOCKED,
    S_FAULT
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [TMR_W-1:0]      r_tmr, w_tmr_nxt;
  logic [CNT_WIDTH-1:0]  r_target, w_target_nxt;
  logic [CTRL_WIDTH-1:0] r_freq_sel, w_freq_sel_nxt;
  logic                  r_meas_req, w_meas_req_nxt;
  logic                  r_osc_en, w_osc_en_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_locked, w_locked_nxt;
  logic                  r_fault, w_fault_nxt;
  logic                  w_start_acc;

  assign w_start_acc = start_i &&
                       (r_state == S_IDLE || r_state == S_LOCKED || r_state == S_FAULT);

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_tmr      <= '0;
      r_target   <= '0;
      r_freq_sel <= '0;
      r_meas_req <= 1'b0;
      r_osc_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_locked   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_tmr      <= w_tmr_nxt;
      r_target   <= w_target_nxt;
      r_freq_sel <= w_freq_sel_nxt;
      r_meas_req <= w_meas_req_nxt;
      r_osc_en   <= w_osc_en_nxt;
      r_busy     <= w_busy_nxt;
      r_locked   <= w_locked_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (stop_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_LOCKED, S_FAULT: if (start_i) w_state_nxt = S_SETTLE;
        S_SETTLE:                  if (r_tmr == SETTLE_LAST) w_state_nxt = S_MEASURE;
        S_MEASURE: begin
          if (meas_valid_i)                w_state_nxt = (r_idx == '0) ? S_LOCKED : S_SETTLE;
          else if (r_tmr == TIMEOUT_LAST)  w_state_nxt = S_FAULT;
        end
        default:                   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered: their next values are decoded from the next state.
  always_comb begin
    w_idx_nxt      = r_idx;
    w_target_nxt   = r_target;
    w_freq_sel_nxt = r_freq_sel;
    w_tmr_nxt      = '0;
    if (w_state_nxt == r_state && (r_state == S_SETTLE || r_state == S_MEASURE))
      w_tmr_nxt = r_tmr + 1'b1;

    if (stop_i) begin
      w_freq_sel_nxt = '0;
      w_idx_nxt      = '0;
    end else if (w_start_acc) begin
      w_freq_sel_nxt = SEL_MSB;
      w_idx_nxt      = IDX_MSB;
      w_target_nxt   = target_cnt_i;
    end else if (r_state == S_MEASURE && meas_valid_i) begin
      // Oscillator too fast: drop the trial bit; equal counts keep it.
      if (meas_cnt_i > r_target) w_freq_sel_nxt[r_idx] = 1'b0;
      if (r_idx != '0) begin
        w_freq_sel_nxt[r_idx - 1'b1] = 1'b1;
        w_idx_nxt                    = r_idx - 1'b1;
      end
    end else if (w_state_nxt == S_FAULT) begin
      w_freq_sel_nxt = '0;
    end

    w_busy_nxt     = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_MEASURE);
    w_osc_en_nxt   = w_busy_nxt || (w_state_nxt == S_LOCKED);
    w_meas_req_nxt = (w_state_nxt == S_MEASURE);
    w_locked_nxt   = (w_state_nxt == S_LOCKED);
    w_fault_nxt    = (w_state_nxt == S_FAULT);
  end

  assign meas_req_o   = r_meas_req;
  assign osc_enable_o = r_osc_en;
  assign freq_sel_o   = r_freq_sel;
  assign busy_o       = r_busy;
  assign locked_o     = r_locked;
  assign fault_o      = r_fault;

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Bench for dco_tune_ctrl: a counter model answers meas_req_o with count = 100*freq_sel,
// and a monitor checks every trial, lock and settle interval against queued expectations.
module tb_dco_tune_ctrl;

  localparam int CW      = 5;
  localparam int NW      = 16;
  localparam int SETTLE  = 64;
  localparam int TIMEOUT = 4096;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          start_i;
  logic          stop_i;
  logic [NW-1:0] target_cnt_i;
  logic [NW-1:0] meas_cnt_i;
  logic          meas_valid_i;
  logic          meas_req_o;
  logic          osc_enable_o;
  logic [CW-1:0] freq_sel_o;
  logic          busy_o;
  logic          locked_o;
  logic          fault_o;

  logic          rsp_en;
  logic          rsp_valid;
  logic [NW-1:0] rsp_cnt;
  logic          inj_valid;
  logic [NW-1:0] inj_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int trial_q[$];
  int lock_q[$];

  assign meas_valid_i = rsp_valid | inj_valid;
  assign meas_cnt_i   = inj_valid ? inj_cnt : rsp_cnt;

  always #5 clk_i = ~clk_i;

  dco_tune_ctrl #(
    .CTRL_WIDTH    (CW),
    .CNT_WIDTH     (NW),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .target_cnt_i(target_cnt_i),
    .meas_cnt_i  (meas_cnt_i),
    .meas_valid_i(meas_valid_i),
    .meas_req_o  (meas_req_o),
    .osc_enable_o(osc_enable_o),
    .freq_sel_o  (freq_sel_o),
    .busy_o      (busy_o),
    .locked_o    (locked_o),
    .fault_o     (fault_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Frequency counter model: answers a request three cycles later with 100*freq_sel.
  initial begin : responder
    int lat;
    lat       = 0;
    rsp_valid = 1'b0;
    rsp_cnt   = '0;
    forever begin
      @(negedge clk_i);
      rsp_valid = 1'b0;
      if (rsp_en && meas_req_o) begin
        if (lat == 3) begin
          rsp_valid = 1'b1;
          rsp_cnt   = NW'(100 * freq_sel_o);
          lat       = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Scoreboard monitor: every meas_req_o rise and locked_o rise consumes one expectation.
  initial begin : monitor
    int            cyc;
    int            last_change;
    logic          prev_req;
    logic          prev_lock;
    logic [CW-1:0] prev_sel;
    cyc = 0; last_change = 0; prev_req = 1'b0; prev_lock = 1'b0; prev_sel = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (freq_sel_o !== prev_sel) last_change = cyc;
      if (meas_req_o === 1'b1 && prev_req !== 1'b1) begin
        check("settle_len", cyc - last_change, SETTLE);
        check("trial_expected", trial_q.size() != 0, 1);
        if (trial_q.size() != 0) check("trial_sel", freq_sel_o, trial_q.pop_front());
      end
      if (locked_o === 1'b1 && prev_lock !== 1'b1) begin
        check("lock_expected", lock_q.size() != 0, 1);
        if (lock_q.size() != 0) check("lock_sel", freq_sel_o, lock_q.pop_front());
        check("lock_busy", busy_o, 0);
      end
      prev_req  = meas_req_o;
      prev_lock = locked_o;
      prev_sel  = freq_sel_o;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic pulse_start(input int tgt);
    target_cnt_i = NW'(tgt);
    start_i      = 1'b1;
    @(negedge clk_i);
    start_i      = 1'b0;
  endtask

  task automatic push_run(input int t0, input int t1, input int t2, input int t3,
                          input int t4, input int fin);
    trial_q.push_back(t0); trial_q.push_back(t1); trial_q.push_back(t2);
    trial_q.push_back(t3); trial_q.push_back(t4);
    lock_q.push_back(fin);
  endtask

  task automatic wait_lock(input string name, input int fin);
    int n;
    n = 0;
    while (locked_o !== 1'b1 && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_locked"}, locked_o, 1);
    tick(20);
    check({name, "_held_sel"}, freq_sel_o, fin);
    check({name, "_osc_req_busy"}, {osc_enable_o, meas_req_o, busy_o}, 3'b100);
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (meas_req_o !== 1'b1 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_req_seen"}, meas_req_o, 1);
  endtask

  initial begin : stimulus
    int n;
    rst_n_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; target_cnt_i = '0;
    rsp_en = 1'b0; inj_valid = 1'b0; inj_cnt = '0;
    #1;
    check("reset_outputs",
          {meas_req_o, osc_enable_o, busy_o, locked_o, fault_o, freq_sel_o}, 0);
    #21 rst_n_i = 1'b1;
    tick(2);
    rsp_en = 1'b1;

    // Reference sweep: target 1050 -> trials 16,8,12,10,11, lock at 10.
    push_run(16, 8, 12, 10, 11, 10);
    pulse_start(1050);
    check("start_outputs", {osc_enable_o, busy_o, locked_o, fault_o, freq_sel_o},
          {4'b1100, 5'd16});
    wait_lock("t1050", 10);

    // Equality keeps the bit; early meas_valid and start while busy are both ignored.
    push_run(16, 24, 20, 22, 21, 20);
    pulse_start(2000);
    tick(5);
    inj_cnt = '0; inj_valid = 1'b1;
    tick(3);
    inj_valid = 1'b0;
    pulse_start(5);
    check("busy_start_ignored", {busy_o, freq_sel_o}, {1'b1, 5'd16});
    wait_lock("t2000", 20);

    push_run(16, 8, 4, 2, 1, 0);
    pulse_start(0);
    wait_lock("t0", 0);

    push_run(16, 24, 28, 30, 31, 31);
    pulse_start(65535);
    wait_lock("t65535", 31);
    inj_cnt = '0; inj_valid = 1'b1;
    tick(2);
    inj_valid = 1'b0;
    tick(2);
    check("locked_valid_ignored", {locked_o, freq_sel_o}, {1'b1, 5'd31});

    // Timeout: the counter never answers the first request.
    rsp_en = 1'b0;
    trial_q.push_back(16);
    pulse_start(1050);
    wait_req("timeout");
    n = 0;
    while (fault_o !== 1'b1 && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    check("timeout_cycles", n, TIMEOUT);
    check("fault_outputs",
          {fault_o, osc_enable_o, busy_o, meas_req_o, locked_o, freq_sel_o}, {5'b10000, 5'd0});
    rsp_en = 1'b1;
    push_run(16, 8, 12, 10, 11, 10);
    pulse_start(1050);
    check("fault_restart", {fault_o, busy_o, osc_enable_o, freq_sel_o}, {3'b011, 5'd16});
    wait_lock("after_fault", 10);

    // Stop together with start during the third SETTLE.
    trial_q.push_back(16); trial_q.push_back(8);
    pulse_start(1050);
    n = 0;
    while (!(freq_sel_o == 5'd12 && busy_o === 1'b1 && meas_req_o === 1'b0) && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    check("third_settle_reached", freq_sel_o, 12);
    tick(10);
    start_i = 1'b1; stop_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; stop_i = 1'b0;
    check("stop_outputs",
          {meas_req_o, osc_enable_o, busy_o, locked_o, fault_o, freq_sel_o}, 0);
    tick(150);
    check("stop_stays_idle", {meas_req_o, busy_o, osc_enable_o}, 0);

    // Asynchronous reset in the middle of MEASURE.
    rsp_en = 1'b0;
    trial_q.push_back(16);
    pulse_start(1050);
    wait_req("reset");
    tick(3);
    #2 rst_n_i = 1'b0;
    #1 check("async_reset_outputs",
             {meas_req_o, osc_enable_o, busy_o, locked_o, fault_o, freq_sel_o}, 0);
    #1 rst_n_i = 1'b1;
    rsp_en = 1'b1;
    tick(150);
    check("reset_no_resume", {meas_req_o, busy_o, osc_enable_o}, 0);

    push_run(16, 24, 20, 22, 21, 20);
    pulse_start(2000);
    wait_lock("after_reset", 20);

    check("trial_q_drained", trial_q.size(), 0);
    check("lock_q_drained", lock_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
